// File: rtl/axi_buf_slave_pkg.sv
// rtl/axi_buf_slave_pkg.sv - shared AXI response/burst encodings and FSM state types
package axi_buf_slave_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_buf_slave_rd_fifo.sv
// rtl/axi_buf_slave_rd_fifo.sv - 2-entry read-return FIFO holding {data, resp, last}
module axi_rd_skid_fifo #(
  parameter int W = 131
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  // Callers never push when full or pop when empty.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + 2'(push) - 2'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/axi_buf_slave.sv
// rtl/axi_buf_slave.sv - AXI4 subordinate converting read/write bursts into buffer word accesses
module axi_buf_slave
  import axi_buf_slave_pkg::*;
#(
  parameter int                    AXI_DATA_W = 128,
  parameter int                    AXI_ADDR_W = 40,
  parameter int                    BUF_ADDR_W = 18,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                    DEPTH      = 2**18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [AXI_DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    buf_wr_en,
  output logic [BUF_ADDR_W-1:0]   buf_wr_addr,
  output logic [AXI_DATA_W-1:0]   buf_wr_data,
  output logic [AXI_DATA_W/8-1:0] buf_wr_strb,
  output logic                    buf_rd_en,
  output logic [BUF_ADDR_W-1:0]   buf_rd_addr,
  input  logic [AXI_DATA_W-1:0]   buf_rd_data
);

  localparam int                  BYTES     = AXI_DATA_W / 8;
  localparam int                  LSB       = $clog2(BYTES);
  localparam logic [2:0]          FULL_SIZE = 3'(LSB);
  localparam logic [AXI_ADDR_W:0] BASE_EXT  = {1'b0, BASE_ADDR};
  localparam logic [AXI_ADDR_W:0] DEPTH_EXT = (AXI_ADDR_W+1)'(DEPTH);
  localparam int                  FIFO_W    = AXI_DATA_W + 3;

  // Range arithmetic is one bit wider than the address so the window end never overflows.
  function automatic axi_resp_e classify(input logic [AXI_ADDR_W-1:0] addr,
                                         input logic [7:0]            len,
                                         input logic [2:0]            size,
                                         input logic [1:0]            burst);
    logic [AXI_ADDR_W:0] start_ext;
    logic [AXI_ADDR_W:0] word;
    logic [AXI_ADDR_W:0] span;
    start_ext = {1'b0, addr};
    word      = (start_ext - BASE_EXT) >> LSB;
    span      = (burst == AXI_BURST_FIXED) ? '0 : (AXI_ADDR_W+1)'(len);
    if (start_ext < BASE_EXT || (word + span) >= DEPTH_EXT) begin
      return DECERR;
    end
    if (size != FULL_SIZE || burst == AXI_BURST_WRAP || burst == 2'b11) begin
      return SLVERR;
    end
    return OKAY;
  endfunction

  function automatic logic [BUF_ADDR_W-1:0] word_index(input logic [AXI_ADDR_W-1:0] addr);
    return BUF_ADDR_W'(({1'b0, addr} - BASE_EXT) >> LSB);
  endfunction

  // Readies stay low until the first clock after reset release.
  logic run_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // ---------------- write path ----------------
  wr_state_e             w_state_q, w_state_d;
  logic [BUF_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  w_fixed_q, w_fixed_d;
  axi_resp_e             w_err_q, w_err_d;
  logic                  w_last_bad_q, w_last_bad_d;
  axi_resp_e             b_resp_q, b_resp_d;
  axi_resp_e             aw_class;
  logic                  w_beat_last;
  logic                  w_last_bad_now;

  assign aw_class = classify(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);

  always_comb begin
    w_state_d      = w_state_q;
    w_addr_d       = w_addr_q;
    w_len_d        = w_len_q;
    w_cnt_d        = w_cnt_q;
    w_fixed_d      = w_fixed_q;
    w_err_d        = w_err_q;
    w_last_bad_d   = w_last_bad_q;
    b_resp_d       = b_resp_q;
    s_axi_awready  = 1'b0;
    s_axi_wready   = 1'b0;
    s_axi_bvalid   = 1'b0;
    buf_wr_en      = 1'b0;
    w_beat_last    = (w_cnt_q == w_len_q);
    w_last_bad_now = w_last_bad_q | (s_axi_wlast != w_beat_last);
    case (w_state_q)
      W_IDLE: begin
        s_axi_awready = run_q;
        if (run_q && s_axi_awvalid) begin
          w_addr_d     = word_index(s_axi_awaddr);
          w_len_d      = s_axi_awlen;
          w_cnt_d      = 8'd0;
          w_fixed_d    = (s_axi_awburst == AXI_BURST_FIXED);
          w_err_d      = aw_class;
          w_last_bad_d = 1'b0;
          w_state_d    = W_DATA;
        end
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          buf_wr_en    = (w_err_q == OKAY);
          w_last_bad_d = w_last_bad_now;
          // The beat count, not WLAST, ends the burst; a WLAST mismatch only taints the response.
          if (w_beat_last) begin
            w_state_d = W_RESP;
            if (w_err_q != OKAY)     b_resp_d = w_err_q;
            else if (w_last_bad_now) b_resp_d = SLVERR;
            else                     b_resp_d = OKAY;
          end else begin
            w_cnt_d  = w_cnt_q + 8'd1;
            w_addr_d = w_addr_q + {{(BUF_ADDR_W-1){1'b0}}, ~w_fixed_q};
          end
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q    <= W_IDLE;
      w_addr_q     <= '0;
      w_len_q      <= 8'd0;
      w_cnt_q      <= 8'd0;
      w_fixed_q    <= 1'b0;
      w_err_q      <= OKAY;
      w_last_bad_q <= 1'b0;
      b_resp_q     <= OKAY;
    end else begin
      w_state_q    <= w_state_d;
      w_addr_q     <= w_addr_d;
      w_len_q      <= w_len_d;
      w_cnt_q      <= w_cnt_d;
      w_fixed_q    <= w_fixed_d;
      w_err_q      <= w_err_d;
      w_last_bad_q <= w_last_bad_d;
      b_resp_q     <= b_resp_d;
    end
  end

  assign s_axi_bresp = b_resp_q;
  assign buf_wr_addr = w_addr_q;
  assign buf_wr_data = s_axi_wdata;
  assign buf_wr_strb = s_axi_wstrb;

  // ---------------- read path ----------------
  rd_state_e             r_state_q, r_state_d;
  logic [BUF_ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [8:0]            r_issued_q, r_issued_d;
  logic                  r_fixed_q, r_fixed_d;
  axi_resp_e             r_err_q, r_err_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  axi_resp_e             ar_class;
  logic                  rd_issue;
  logic [2:0]            rd_occ;
  logic                  fifo_pop;
  logic [1:0]            fifo_count;
  logic [FIFO_W-1:0]     fifo_push_data;
  logic [FIFO_W-1:0]     fifo_head;
  logic [AXI_DATA_W-1:0] ret_data;

  assign ar_class = classify(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
  assign fifo_pop = s_axi_rvalid && s_axi_rready;
  // Counting this cycle's pop as free space is what sustains one beat per cycle.
  assign rd_occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
  assign rd_issue = (r_state_q == R_DATA) && (r_issued_q <= {1'b0, r_len_q}) && (rd_occ < 3'd2);

  always_comb begin
    r_state_d       = r_state_q;
    r_addr_d        = r_addr_q;
    r_len_d         = r_len_q;
    r_issued_d      = r_issued_q;
    r_fixed_d       = r_fixed_q;
    r_err_d         = r_err_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    s_axi_arready   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axi_arready = run_q;
        if (run_q && s_axi_arvalid) begin
          r_addr_d   = word_index(s_axi_araddr);
          r_len_d    = s_axi_arlen;
          r_issued_d = 9'd0;
          r_fixed_d  = (s_axi_arburst == AXI_BURST_FIXED);
          r_err_d    = ar_class;
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (rd_issue) begin
          inflight_d      = 1'b1;
          inflight_last_d = (r_issued_q == {1'b0, r_len_q});
          r_issued_d      = r_issued_q + 9'd1;
          r_addr_d        = r_addr_q + {{(BUF_ADDR_W-1){1'b0}}, ~r_fixed_q};
        end
        if (fifo_pop && s_axi_rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q       <= R_IDLE;
      r_addr_q        <= '0;
      r_len_q         <= 8'd0;
      r_issued_q      <= 9'd0;
      r_fixed_q       <= 1'b0;
      r_err_q         <= OKAY;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      r_state_q       <= r_state_d;
      r_addr_q        <= r_addr_d;
      r_len_q         <= r_len_d;
      r_issued_q      <= r_issued_d;
      r_fixed_q       <= r_fixed_d;
      r_err_q         <= r_err_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // Error bursts run the same slot pipeline but never touch the buffer and return zeros.
  assign buf_rd_en      = rd_issue && (r_err_q == OKAY);
  assign buf_rd_addr    = r_addr_q;
  assign ret_data       = (r_err_q == OKAY) ? buf_rd_data : '0;
  assign fifo_push_data = {ret_data, r_err_q, inflight_last_q};

  axi_rd_skid_fifo #(
    .W (FIFO_W)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign s_axi_rvalid = (fifo_count != 2'd0);
  assign s_axi_rdata  = fifo_head[FIFO_W-1:3];
  assign s_axi_rresp  = fifo_head[2:1];
  assign s_axi_rlast  = fifo_head[0];

endmodule

// File: tb/tb_axi_buf_slave.sv
// tb/tb_axi_buf_slave.sv - randomized scoreboard bench for axi_buf_slave
module tb_axi_buf_slave;
  import axi_buf_slave_pkg::*;

  localparam int          DW    = 128;
  localparam int          AW    = 40;
  localparam int          BW    = 8;
  localparam int          DEPTH = 256;
  localparam logic [39:0] BASE  = 40'h0000_0100_00;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [15:0]   wstrb;
  logic          wlast, wvalid, wready;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, rlast, rvalid, rready;
  logic          buf_wr_en, buf_rd_en;
  logic [BW-1:0] buf_wr_addr, buf_rd_addr;
  logic [DW-1:0] buf_wr_data, buf_rd_data;
  logic [15:0]   buf_wr_strb;

  always #5 clk = ~clk;

  axi_buf_slave #(
    .AXI_DATA_W(DW), .AXI_ADDR_W(AW), .BUF_ADDR_W(BW), .BASE_ADDR(BASE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_wr_strb(buf_wr_strb),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data)
  );

  // Bench-side buffer: byte-enabled writes, one-cycle read latency.
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (buf_wr_en)
      for (int b = 0; b < 16; b++)
        if (buf_wr_strb[b]) sram[buf_wr_addr][b*8 +: 8] <= buf_wr_data[b*8 +: 8];
    if (buf_rd_en) buf_rd_data <= sram[buf_rd_addr];
  end

  typedef struct { logic [BW-1:0] addr; logic [DW-1:0] data; logic [15:0] strb; } wr_t;
  typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; } rbeat_t;

  wr_t           exp_wr_q[$];
  logic [1:0]    exp_b_q[$];
  rbeat_t        exp_r_q[$];
  logic [BW-1:0] exp_rd_q[$];
  logic [DW-1:0] ref_mem [DEPTH];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Reference model: error class and word index from plain address arithmetic.
  function automatic logic [1:0] model_class(input logic [39:0] addr, input int len,
                                             input logic [2:0] size, input logic [1:0] burst);
    longint a, word, span;
    a = longint'(addr);
    if (a < longint'(BASE)) return 2'b11;
    word = (a - longint'(BASE)) / 16;
    span = (burst == AXI_BURST_FIXED) ? 0 : len;
    if (word + span >= DEPTH) return 2'b11;
    if (size != 3'd4 || burst == 2'b10 || burst == 2'b11) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int word_of(input logic [39:0] addr);
    return int'((longint'(addr) - longint'(BASE)) / 16);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_rdata;
  logic [1:0]    prev_rresp;
  logic          prev_rlast;
  int            outstanding = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_wr_q.delete();
      exp_b_q.delete();
      exp_r_q.delete();
      exp_rd_q.delete();
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (buf_wr_en) begin
        if (exp_wr_q.size() == 0) fail("unexpected buf_wr_en");
        else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("buf_wr_addr", buf_wr_addr, e.addr);
          check("buf_wr_data", buf_wr_data, e.data);
          check("buf_wr_strb", buf_wr_strb, e.strb);
        end
      end
      if (buf_rd_en) begin
        if (exp_rd_q.size() == 0) fail("unexpected buf_rd_en");
        else check("buf_rd_addr", buf_rd_addr, exp_rd_q.pop_front());
        check("reads outstanding <= 2", 128'(outstanding <= 2), 128'(1));
      end
      if (prev_stall) begin
        check("rvalid held while stalled", rvalid, 1'b1);
        check("rdata stable while stalled", rdata, prev_rdata);
        check("rresp/rlast stable while stalled", {rresp, rlast}, {prev_rresp, prev_rlast});
      end
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) fail("unexpected B handshake");
        else check("bresp", bresp, exp_b_q.pop_front());
      end
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) fail("unexpected R handshake");
        else begin
          rbeat_t e;
          e = exp_r_q.pop_front();
          check("rdata", rdata, e.data);
          check("rresp", rresp, e.resp);
          check("rlast", rlast, e.last);
        end
      end
      outstanding += int'(buf_rd_en);
      if (rvalid && rready && rresp == 2'b00) outstanding--;
      prev_stall = rvalid && !rready;
      prev_rdata = rdata;
      prev_rresp = rresp;
      prev_rlast = rlast;
    end
  end

  // ---------------- drivers ----------------
  task automatic aw_hs(input logic [39:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [1:0] b);
    int n = 0;
    awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (awready) break;
      if (++n > 200) begin fail("AW handshake timeout"); break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic ar_hs(input logic [39:0] a, input logic [7:0] l, input logic [2:0] s,
                       input logic [1:0] b);
    int n = 0;
    araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (arready) break;
      if (++n > 200) begin fail("AR handshake timeout"); break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input logic [15:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (wready) break;
      if (++n > 200) begin fail("W handshake timeout"); break; end
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  // lastmode: 0 correct WLAST, 1 WLAST missing on final beat, 2 WLAST early on beat 0
  task automatic do_write(input logic [39:0] a, input int len, input logic [2:0] s,
                          input logic [1:0] b, input logic [15:0] strb_fix, input int lastmode);
    logic [1:0] cls;
    int         word, n, d;
    logic       bad;
    cls  = model_class(a, len, s, b);
    word = word_of(a);
    bad  = 1'b0;
    aw_hs(a, 8'(len), s, b);
    for (int i = 0; i <= len; i++) begin
      logic [DW-1:0] data;
      logic [15:0]   st;
      logic          l;
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      data = {$urandom, $urandom, $urandom, $urandom};
      st   = (strb_fix != 16'h0) ? strb_fix : 16'($urandom);
      l    = (i == len);
      if (lastmode == 1 && i == len) l = 1'b0;
      if (lastmode == 2 && i == 0 && len > 0) l = 1'b1;
      if (l != (i == len)) bad = 1'b1;
      if (cls == 2'b00) begin
        wr_t e;
        e.addr = BW'(word + ((b == AXI_BURST_FIXED) ? 0 : i));
        e.data = data;
        e.strb = st;
        exp_wr_q.push_back(e);
        for (int k = 0; k < 16; k++)
          if (st[k]) ref_mem[e.addr][k*8 +: 8] = data[k*8 +: 8];
      end
      w_beat(data, st, l);
    end
    wlast = 1'b0;
    exp_b_q.push_back((cls != 2'b00) ? cls : (bad ? 2'b10 : 2'b00));
    @(negedge clk);
    check("bvalid in cycle after last W", bvalid, 1'b1);
    @(posedge clk); #1;
    d = $urandom_range(0, 2);
    repeat (d) begin @(posedge clk); #1; end
    bready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bvalid) break;
      if (++n > 200) begin fail("B timeout"); break; end
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // rmode: 0 always ready, 1 toggling, 2 random
  task automatic do_read(input logic [39:0] a, input int len, input logic [2:0] s,
                         input logic [1:0] b, input int rmode);
    logic [1:0] cls;
    int         word, got, cyc, first;
    cls  = model_class(a, len, s, b);
    word = word_of(a);
    for (int i = 0; i <= len; i++) begin
      rbeat_t e;
      int     w;
      w      = word + ((b == AXI_BURST_FIXED) ? 0 : i);
      e.data = (cls == 2'b00) ? ref_mem[w] : '0;
      e.resp = cls;
      e.last = (i == len);
      exp_r_q.push_back(e);
      if (cls == 2'b00) exp_rd_q.push_back(BW'(w));
    end
    ar_hs(a, 8'(len), s, b);
    got = 0; cyc = 0; first = -1;
    while (got <= len) begin
      if (cyc > 1000) begin fail("R beats timeout"); break; end
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = cyc[0];
        default: rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (rvalid && first < 0) first = cyc;
      if (rvalid && rready) got++;
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    if (rmode == 0) begin
      check("first R beat 2 cycles after AR", 128'(first), 128'(2));
      check("back-to-back R throughput", 128'(cyc), 128'(len + 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    logic [DW-1:0] d0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      sram[i]    = '0;
    end
    rst_n = 1'b0;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset valid/ready/en outputs",
          {awready, wready, bvalid, arready, rvalid, buf_wr_en, buf_rd_en}, 7'b0);
    check("reset bresp/rresp", {bresp, rresp}, 4'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // INCR write/read-back at BASE+0x40 (word 4..7)
    do_write(BASE + 40'h40, 3, 3'd4, AXI_BURST_INCR, 16'hFFFF, 0);
    do_read (BASE + 40'h40, 3, 3'd4, AXI_BURST_INCR, 0);
    // 8-beat read with toggling rready
    do_write(BASE + 40'h200, 7, 3'd4, AXI_BURST_INCR, 16'h0, 0);
    do_read (BASE + 40'h200, 7, 3'd4, AXI_BURST_INCR, 1);
    // window overrun and below-base accesses
    do_write(BASE + 40'((DEPTH - 2) * 16), 3, 3'd4, AXI_BURST_INCR, 16'hFFFF, 0);
    do_read (BASE - 40'h10, 1, 3'd4, AXI_BURST_INCR, 0);
    do_read (BASE + 40'((DEPTH - 1) * 16), 0, 3'd4, AXI_BURST_INCR, 0);
    // unsupported size and WRAP burst
    do_read (BASE + 40'h40, 3, 3'd3, AXI_BURST_INCR, 0);
    do_write(BASE + 40'h80, 3, 3'd4, AXI_BURST_WRAP, 16'hFFFF, 0);
    // FIXED burst with partial strobes, then read the word back three times
    do_write(BASE + 40'h300, 2, 3'd4, AXI_BURST_FIXED, 16'h00FF, 0);
    do_read (BASE + 40'h300, 2, 3'd4, AXI_BURST_FIXED, 2);
    // WLAST missing / early: still writes, SLVERR response
    do_write(BASE + 40'h400, 2, 3'd4, AXI_BURST_INCR, 16'h0, 1);
    do_write(BASE + 40'h440, 2, 3'd4, AXI_BURST_INCR, 16'h0, 2);
    do_read (BASE + 40'h400, 7, 3'd4, AXI_BURST_INCR, 0);

    for (int it = 0; it < 12; it++) begin
      int          len, word;
      logic [1:0]  b;
      logic [39:0] a;
      len  = $urandom_range(0, 15);
      word = $urandom_range(0, DEPTH - 1 - len);
      b    = ($urandom_range(0, 4) == 0) ? AXI_BURST_FIXED : AXI_BURST_INCR;
      a    = BASE + 40'(word * 16) + 40'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) a = BASE + 40'((DEPTH - 1) * 16) + 40'h10 * 40'(len);
      do_write(a, len, 3'd4, b, 16'h0, 0);
      do_read (a, len, 3'd4, b, $urandom_range(0, 2));
    end

    // reset during a write burst and during beat 2 of an 8-beat read
    aw_hs(BASE + 40'h500, 8'd3, 3'd4, AXI_BURST_INCR);
    d0 = {$urandom, $urandom, $urandom, $urandom};
    begin
      wr_t e;
      e.addr = BW'(word_of(BASE + 40'h500));
      e.data = d0;
      e.strb = 16'hFFFF;
      exp_wr_q.push_back(e);
      ref_mem[e.addr] = d0;
    end
    w_beat(d0, 16'hFFFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rbeat_t e;
      e.data = ref_mem[word_of(BASE + 40'h200) + i];
      e.resp = 2'b00;
      e.last = (i == 7);
      exp_r_q.push_back(e);
      exp_rd_q.push_back(BW'(word_of(BASE + 40'h200) + i));
    end
    ar_hs(BASE + 40'h200, 8'd7, 3'd4, AXI_BURST_INCR);
    rready = 1'b1;
    got = 0;
    for (int c = 0; c < 50 && got < 2; c++) begin
      @(negedge clk);
      if (rvalid && rready) got++;
      @(posedge clk); #1;
    end
    check("two R beats before reset", 128'(got), 128'(2));
    wdata = {$urandom, $urandom, $urandom, $urandom};
    wvalid = 1'b1;
    rst_n  = 1'b0;
    #1;
    check("mid-burst reset outputs",
          {awready, wready, bvalid, arready, rvalid, buf_wr_en, buf_rd_en}, 7'b0);
    @(negedge clk);
    wvalid = 1'b0;
    rready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read (BASE + 40'h200, 7, 3'd4, AXI_BURST_INCR, 0);
    do_write(BASE + 40'h500, 3, 3'd4, AXI_BURST_INCR, 16'h0, 0);
    do_read (BASE + 40'h500, 3, 3'd4, AXI_BURST_INCR, 2);

    repeat (4) @(posedge clk);
    #1;
    check("write scoreboard drained", 128'(exp_wr_q.size()), 128'(0));
    check("read scoreboard drained", 128'(exp_r_q.size() + exp_rd_q.size()), 128'(0));
    check("bresp scoreboard drained", 128'(exp_b_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
